// File: rtl/fairy_cp0_pkg.sv
// Shared CP0 definitions for the fairy pipeline: register addresses, ExcCodes, Status bit positions.
// Optional timer (Compare/TI) is enabled by defining FAIRY_CP0_TIMER_EN.
package fairy_cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_BEV   = 22;

  function automatic logic [31:0] status_word(input logic bev, input logic [7:0] im,
                                              input logic exl, input logic ie);
    logic [31:0] w;
    w = '0;
    w[ST_BEV]              = bev;
    w[ST_IM_LO +: 8]       = im;
    w[ST_EXL]              = exl;
    w[ST_IE]               = ie;
    return w;
  endfunction

endpackage

// File: rtl/fairy_cp0_timer.sv
// Count prescaler, Count register and (with FAIRY_CP0_TIMER_EN) Compare register plus TI flag.
module fairy_cp0_timer
  import fairy_cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic          wrap;

  always_comb begin
    wrap    = (presc_q == PRESC_MAX);
    presc_d = wrap ? '0 : presc_q + PW'(1);
    count_d = wrap ? count_q + 32'd1 : count_q;
    // A software load restarts the prescale period and swallows this cycle's tick.
    if (count_we_i) begin
      presc_d = '0;
      count_d = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

`ifdef FAIRY_CP0_TIMER_EN
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    compare_d = compare_q;
    ti_d      = ti_q;
    if (wrap && !count_we_i && (count_q + 32'd1 == compare_q)) ti_d = 1'b1;
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign compare_o = compare_q;
  assign ti_o      = ti_q;
`else
  logic unused_compare_we;
  assign unused_compare_we = compare_we_i;
  assign compare_o         = '0;
  assign ti_o              = 1'b0;
`endif

endmodule

// File: rtl/fairy_cp0_unit.sv
// CP0 register file and exception/interrupt controller: Status, Cause, EPC, BadVAddr, hw_int sync, int_req.
// Define FAIRY_CP0_TIMER_EN to add Compare and the timer interrupt on IP[7].
module fairy_cp0_unit
  import fairy_cp0_pkg::*;
#(
  parameter int NUM_HW_INT  = 6,
  parameter int COUNT_DIV   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic                  exc_badv_vld,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  input  logic                  mtc0_we,
  input  logic [4:0]            cp0_addr,
  input  logic [31:0]           mtc0_wdata,
  output logic [31:0]           mfc0_rdata,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic                  int_req,
  output logic                  exl,
  output logic [31:0]           epc
);

  logic            bev_q, bev_d;
  logic [7:0]      im_q, im_d;
  logic            exl_q, exl_d;
  logic            ie_q, ie_d;
  logic            bd_q, bd_d;
  logic [4:0]      exccode_q, exccode_d;
  logic [1:0]      ip_sw_q, ip_sw_d;
  logic [31:0]     epc_q, epc_d;
  logic [31:0]     badvaddr_q, badvaddr_d;
  logic            int_req_q, int_req_d;

  logic [NUM_HW_INT-1:0] sync_q [SYNC_STAGES];
  logic [7:0]      ip;
  logic            take_eret, take_mtc0;
  logic [31:0]     count, compare;
  logic            ti;

  assign take_eret = eret & ~exc_valid;
  assign take_mtc0 = mtc0_we & ~exc_valid & ~eret;

  fairy_cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .count_we_i   (take_mtc0 && cp0_addr == CP0_COUNT),
    .compare_we_i (take_mtc0 && cp0_addr == CP0_COMPARE),
    .wdata_i      (mtc0_wdata),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // IP is a live view of the synchronised lines; nothing is latched here.
  always_comb begin
    ip      = 8'b0;
    ip[1:0] = ip_sw_q;
    for (int i = 0; i < NUM_HW_INT; i++) ip[2+i] = sync_q[SYNC_STAGES-1][i];
`ifdef FAIRY_CP0_TIMER_EN
    ip[7] = ti;
`endif
  end

  always_comb begin
    bev_d      = bev_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    int_req_d  = ie_q & ~exl_q & |(ip & im_q);

    if (exc_valid) begin
      // Nested exceptions keep the original return point.
      if (!exl_q) begin
        epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
        bd_d  = exc_bd;
      end
      exl_d     = 1'b1;
      exccode_d = exc_code;
      if (exc_badv_vld) badvaddr_d = exc_badvaddr;
    end else if (take_eret) begin
      exl_d = 1'b0;
    end else if (take_mtc0) begin
      case (cp0_addr)
        CP0_STATUS: begin
          bev_d = mtc0_wdata[ST_BEV];
          im_d  = mtc0_wdata[ST_IM_LO +: 8];
          exl_d = mtc0_wdata[ST_EXL];
          ie_d  = mtc0_wdata[ST_IE];
        end
        CP0_CAUSE:    ip_sw_d    = mtc0_wdata[9:8];
        CP0_EPC:      epc_d      = mtc0_wdata;
        CP0_BADVADDR: badvaddr_d = mtc0_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bev_q      <= 1'b1;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
      ip_sw_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      int_req_q  <= 1'b0;
    end else begin
      bev_q      <= bev_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      ip_sw_q    <= ip_sw_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      int_req_q  <= int_req_d;
    end
  end

  always_comb begin
    case (cp0_addr)
      CP0_STATUS:   mfc0_rdata = status_word(bev_q, im_q, exl_q, ie_q);
      CP0_CAUSE:    mfc0_rdata = {bd_q, ti, 14'b0, ip, 1'b0, exccode_q, 2'b0};
      CP0_EPC:      mfc0_rdata = epc_q;
      CP0_BADVADDR: mfc0_rdata = badvaddr_q;
      CP0_COUNT:    mfc0_rdata = count;
      CP0_COMPARE:  mfc0_rdata = compare;
      default:      mfc0_rdata = 32'b0;
    endcase
  end

  assign int_req = int_req_q;
  assign exl     = exl_q;
  assign epc     = epc_q;

endmodule

// File: tb/tb_fairy_cp0_unit.sv
// Directed bench for fairy_cp0_unit with default parameters (6 lines, COUNT_DIV=2, SYNC_STAGES=2).
module tb_fairy_cp0_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        exc_valid, exc_bd, exc_badv_vld, eret, mtc0_we;
  logic [4:0]  exc_code, cp0_addr;
  logic [31:0] exc_pc, exc_badvaddr, mtc0_wdata, mfc0_rdata, epc;
  logic [5:0]  hw_int;
  logic        int_req, exl;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fairy_cp0_unit dut (
    .clk(clk), .reset_n(reset_n),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badv_vld(exc_badv_vld), .exc_badvaddr(exc_badvaddr),
    .eret(eret), .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .mtc0_wdata(mtc0_wdata),
    .mfc0_rdata(mfc0_rdata), .hw_int(hw_int), .int_req(int_req), .exl(exl), .epc(epc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    check(tag, mfc0_rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1'b1; cp0_addr = a; mtc0_wdata = d;
    tick();
    mtc0_we = 1'b0;
  endtask

  task automatic take_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                          input logic bv, input logic [31:0] badv);
    exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd;
    exc_badv_vld = bv; exc_badvaddr = badv;
    tick();
    exc_valid = 1'b0; exc_badv_vld = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; exc_valid = 0; exc_code = 0; exc_pc = 0; exc_bd = 0;
    exc_badv_vld = 0; exc_badvaddr = 0; eret = 0; mtc0_we = 0; cp0_addr = 0;
    mtc0_wdata = 0; hw_int = 0;
    tick(); tick();
    reset_n = 1'b1;

    // Reset state
    rd("rst_status", 5'd12, 32'h0040_0000);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    check("rst_int_req", {31'b0, int_req}, 32'h0);
    check("rst_exl", {31'b0, exl}, 32'h0);

    // First exception in delay slot, then nested exception, then ERET
    take_exc(5'd12, 32'h80, 1'b1, 1'b0, 32'h0);
    check("exc1_epc", epc, 32'h7C);
    check("exc1_exl", {31'b0, exl}, 32'h1);
    rd("exc1_cause", 5'd13, 32'h8000_0030);
    take_exc(5'd8, 32'h200, 1'b0, 1'b0, 32'h0);
    check("exc2_epc_held", epc, 32'h7C);
    rd("exc2_cause", 5'd13, 32'h8000_0020);
    eret = 1'b1; tick(); eret = 1'b0;
    check("eret_exl", {31'b0, exl}, 32'h0);
    check("eret_epc", epc, 32'h7C);

    // Exception beats a same-cycle MTC0 to EPC; address error records BadVAddr
    mtc0_we = 1'b1; cp0_addr = 5'd14; mtc0_wdata = 32'h1234;
    take_exc(5'd4, 32'h300, 1'b0, 1'b1, 32'hDEAD_0001);
    mtc0_we = 1'b0;
    check("prio_exc_epc", epc, 32'h300);
    rd("badvaddr", 5'd8, 32'hDEAD_0001);
    eret = 1'b1; tick(); eret = 1'b0;

    // MTC0 EPC; MFC0 sees the old value during the write cycle
    mtc0(5'd14, 32'h1234);
    check("mtc0_epc", epc, 32'h1234);
    mtc0_we = 1'b1; cp0_addr = 5'd14; mtc0_wdata = 32'h5555;
    #1;
    check("mfc0_pre_update", mfc0_rdata, 32'h1234);
    tick(); mtc0_we = 1'b0;
    check("mtc0_epc2", epc, 32'h5555);

    // Unimplemented address, Cause write mask, Status write mask
    mtc0(5'd3, 32'hFFFF_FFFF);
    rd("unimpl_rd", 5'd3, 32'h0);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd("cause_wmask", 5'd13, 32'h0000_0310);
    mtc0(5'd13, 32'h0);
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd("status_wmask", 5'd12, 32'h0040_FF03);
    mtc0(5'd12, 32'h0040_0000);

    // Count prescaler and wrap
    mtc0(5'd9, 32'hFFFF_FFFE);
    rd("count_load", 5'd9, 32'hFFFF_FFFE);
    tick(); tick();
    rd("count_2cyc", 5'd9, 32'hFFFF_FFFF);
    tick(); tick();
    rd("count_wrap", 5'd9, 32'h0);

`ifdef FAIRY_CP0_TIMER_EN
    mtc0(5'd11, 32'd5);
    rd("compare_rd", 5'd11, 32'd5);
    mtc0(5'd9, 32'd3);
    tick(); tick();
    rd("count_4", 5'd9, 32'd4);
    rd("cause_no_ti", 5'd13, 32'h0000_0010);
    tick(); tick();
    rd("count_5", 5'd9, 32'd5);
    rd("cause_ti", 5'd13, 32'h4000_8010);
    mtc0(5'd11, 32'd1000);
    rd("cause_ti_clr", 5'd13, 32'h0000_0010);
`else
    mtc0(5'd11, 32'd5);
    rd("compare_absent", 5'd11, 32'h0);
    rd("cause_no_timer", 5'd13, 32'h0000_0010);
`endif

    // Interrupt latency and EXL masking
    mtc0(5'd12, 32'h0000_0401);
    check("int_idle", {31'b0, int_req}, 32'h0);
    hw_int = 6'b000001;
    tick();
    check("int_lat1", {31'b0, int_req}, 32'h0);
    tick();
    check("int_lat2", {31'b0, int_req}, 32'h0);
    rd("cause_ip2", 5'd13, 32'h0000_0410);
    tick();
    check("int_lat3", {31'b0, int_req}, 32'h1);
    take_exc(5'd0, 32'h400, 1'b0, 1'b0, 32'h0);
    check("int_exc_exl", {31'b0, exl}, 32'h1);
    check("int_still", {31'b0, int_req}, 32'h1);
    tick();
    check("int_drop", {31'b0, int_req}, 32'h0);
    check("int_epc", epc, 32'h400);

    // ERET beats same-cycle MTC0; interrupt re-asserts once EXL clears
    eret = 1'b1; mtc0_we = 1'b1; cp0_addr = 5'd14; mtc0_wdata = 32'hBEEF;
    tick();
    eret = 1'b0; mtc0_we = 1'b0;
    check("eret_prio_epc", epc, 32'h400);
    check("eret_prio_exl", {31'b0, exl}, 32'h0);
    tick();
    check("int_reassert", {31'b0, int_req}, 32'h1);
    hw_int = 6'b0;
    tick(); tick(); tick();
    check("int_release", {31'b0, int_req}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
